icache_data_array_mp: RTL and testbench

Next-generation instruction-cache data array. It holds num_ways ways of cache lines and exposes two independent ports: A for demand fetch/fill and B for prefetch fill/probe.
- Each port does byte-masked writes and registered 1-cycle reads, with same-cycle write-through forwarding across and within ports.
- A built-in init sweep clears every line after reset, so no memory-initialiser is needed.
- Sits between the icache control FSM / prefetcher and the line-select mux feeding the fetch stage.

---
 rtl/icache_dp_pkg.sv | 19 +
 rtl/icache_byte_merge.sv | 29 ++
 rtl/icache_data_array_mp.sv | 117 +++++++++++
 tb/tb_icache_data_array_mp.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_dp_pkg.sv
// Shared geometry and state encoding for the multi-port icache data array.
// Line/set/way sizes are derived here so every file agrees on widths.
package icache_dp_pkg;

  localparam int s_offset = 5;
  localparam int s_index  = 3;
  localparam int s_way    = 1;

  localparam int s_mask   = 2 ** s_offset;
  localparam int s_line   = 8 * s_mask;
  localparam int num_sets = 2 ** s_index;
  localparam int num_ways = 2 ** s_way;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_t;

endpackage

// File: rtl/icache_byte_merge.sv
// Per-byte priority merge: A write bytes beat B write bytes beat the stored line.
// Used both to form read data (forwarding) and the line written back.
module icache_byte_merge
  import icache_dp_pkg::*;
(
  input  logic [s_line-1:0] stored,
  input  logic [s_line-1:0] a_wdata,
  input  logic [s_mask-1:0] a_wmask,
  input  logic              a_hit,
  input  logic [s_line-1:0] b_wdata,
  input  logic [s_mask-1:0] b_wmask,
  input  logic              b_hit,
  output logic [s_line-1:0] line
);

  always_comb begin
    // NOTE: the output gets a full default before any conditional
    // override, so no path leaves it unassigned and no latch is inferred.
    line = stored;
    for (int i = 0; i < s_mask; i++) begin
      if (a_hit && a_wmask[i]) begin
        line[8*i +: 8] = a_wdata[8*i +: 8];
      end else if (b_hit && b_wmask[i]) begin
        line[8*i +: 8] = b_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/icache_data_array_mp.sv
// Two-port icache data array with byte-masked writes, registered reads,
// cross-port write-through forwarding and a post-reset zeroing sweep.
module icache_data_array_mp
  import icache_dp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              ready,

  input  logic              a_read,
  input  logic [s_way-1:0]  a_way,
  input  logic [s_index-1:0] a_set,
  input  logic [s_mask-1:0] a_wmask,
  input  logic [s_line-1:0] a_wdata,
  output logic [s_line-1:0] a_rdata,
  output logic              a_rvalid,

  input  logic              b_read,
  input  logic [s_way-1:0]  b_way,
  input  logic [s_index-1:0] b_set,
  input  logic [s_mask-1:0] b_wmask,
  input  logic [s_line-1:0] b_wdata,
  output logic [s_line-1:0] b_rdata,
  output logic              b_rvalid
);

  logic [s_line-1:0] mem [num_ways][num_sets];

  init_state_t        state_q, state_d;
  logic [s_index-1:0] cnt_q, cnt_d;

  logic              same_tgt;
  logic [s_line-1:0] a_line, b_line;

  // ---------------------------------------------------------------- init FSM
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == s_index'(num_sets - 1)) begin
        state_d = READY;
      end
    end
  end

  assign ready = (state_q == READY);

  // ---------------------------------------------------------- merge network
  // Same merged line serves as forwarded read data and as the write-back value,
  // so a same-target collision writes an identical line from both ports.
  assign same_tgt = (a_way == b_way) && (a_set == b_set);

  icache_byte_merge u_merge_a (
    .stored  (mem[a_way][a_set]),
    .a_wdata (a_wdata),
    .a_wmask (a_wmask),
    .a_hit   (1'b1),
    .b_wdata (b_wdata),
    .b_wmask (b_wmask),
    .b_hit   (same_tgt),
    .line    (a_line)
  );

  icache_byte_merge u_merge_b (
    .stored  (mem[b_way][b_set]),
    .a_wdata (a_wdata),
    .a_wmask (a_wmask),
    .a_hit   (same_tgt),
    .b_wdata (b_wdata),
    .b_wmask (b_wmask),
    .b_hit   (1'b1),
    .line    (b_line)
  );

  // ------------------------------------------------------------------ array
  // NOTE: the storage array has no reset; clearing it is the sweep's job,
  // which keeps it mappable onto RAM macros without a reset network.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      for (int w = 0; w < num_ways; w++) begin
        mem[w[s_way-1:0]][cnt_q] <= '0;
      end
    end else begin
      if (|a_wmask) mem[a_way][a_set] <= a_line;
      if (|b_wmask) mem[b_way][b_set] <= b_line;
    end
  end

  // ------------------------------------------------------------- read ports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata  <= '0;
      a_rvalid <= 1'b0;
      b_rdata  <= '0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= ready && a_read;
      b_rvalid <= ready && b_read;
      if (ready && a_read) a_rdata <= a_line;
      if (ready && b_read) b_rdata <= b_line;
    end
  end

endmodule

// File: tb/tb_icache_data_array_mp.sv
// Scoreboard bench for icache_data_array_mp: a byte-level reference model
// predicts read data at issue time; returned data is popped and compared.
module tb_icache_data_array_mp;
  import icache_dp_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ready;
  logic               a_read, b_read;
  logic [s_way-1:0]   a_way, b_way;
  logic [s_index-1:0] a_set, b_set;
  logic [s_mask-1:0]  a_wmask, b_wmask;
  logic [s_line-1:0]  a_wdata, b_wdata;
  logic [s_line-1:0]  a_rdata, b_rdata;
  logic               a_rvalid, b_rvalid;

  icache_data_array_mp dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .a_read   (a_read),
    .a_way    (a_way),
    .a_set    (a_set),
    .a_wmask  (a_wmask),
    .a_wdata  (a_wdata),
    .a_rdata  (a_rdata),
    .a_rvalid (a_rvalid),
    .b_read   (b_read),
    .b_way    (b_way),
    .b_set    (b_set),
    .b_wmask  (b_wmask),
    .b_wdata  (b_wdata),
    .b_rdata  (b_rdata),
    .b_rvalid (b_rvalid)
  );

  always #5 clk = ~clk;

  logic [s_line-1:0] mdl [num_ways][num_sets];
  logic [s_line-1:0] exp_a_q[$];
  logic [s_line-1:0] exp_b_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  init_cnt = 0;
  logic exp_ready = 1'b0;
  logic a_issued, b_issued;

  task automatic check(input string tag, input logic [s_line-1:0] got,
                       input logic [s_line-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [s_line-1:0] model_read(input logic [s_way-1:0] w,
                                                    input logic [s_index-1:0] s);
    logic [s_line-1:0] r;
    r = mdl[w][s];
    for (int i = 0; i < s_mask; i++) begin
      if (a_wmask[i] && a_way == w && a_set == s)
        r[8*i +: 8] = a_wdata[8*i +: 8];
      else if (b_wmask[i] && b_way == w && b_set == s)
        r[8*i +: 8] = b_wdata[8*i +: 8];
    end
    return r;
  endfunction

  task automatic model_write();
    logic [s_line-1:0] la, lb;
    la = model_read(a_way, a_set);
    lb = model_read(b_way, b_set);
    if (|a_wmask) mdl[a_way][a_set] = la;
    if (|b_wmask) mdl[b_way][b_set] = lb;
  endtask

  task automatic idle_inputs();
    a_read = 0; a_way = '0; a_set = '0; a_wmask = '0; a_wdata = '0;
    b_read = 0; b_way = '0; b_set = '0; b_wmask = '0; b_wdata = '0;
  endtask

  // One clock: predict, advance, then compare ready/rvalid/rdata.
  task automatic step();
    a_issued = exp_ready && a_read;
    b_issued = exp_ready && b_read;
    if (a_issued) exp_a_q.push_back(model_read(a_way, a_set));
    if (b_issued) exp_b_q.push_back(model_read(b_way, b_set));
    if (exp_ready) model_write();
    @(posedge clk);
    #1;
    if (!exp_ready) begin
      init_cnt++;
      if (init_cnt == num_sets) exp_ready = 1'b1;
    end
    check("ready", s_line'(ready), s_line'(exp_ready));
    check("a_rvalid", s_line'(a_rvalid), s_line'(a_issued));
    check("b_rvalid", s_line'(b_rvalid), s_line'(b_issued));
    if (a_rvalid) begin
      if (exp_a_q.size() == 0) check("a_unexpected", s_line'(1), s_line'(0));
      else check("a_rdata", a_rdata, exp_a_q.pop_front());
    end
    if (b_rvalid) begin
      if (exp_b_q.size() == 0) check("b_unexpected", s_line'(1), s_line'(0));
      else check("b_rdata", b_rdata, exp_b_q.pop_front());
    end
    idle_inputs();
  endtask

  // Asserts reset (inputs left as the caller set them), checks the
  // asynchronous effect, then releases mid-cycle.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_ready", s_line'(ready), '0);
    check("rst_a_rvalid", s_line'(a_rvalid), '0);
    check("rst_b_rvalid", s_line'(b_rvalid), '0);
    check("rst_a_rdata", a_rdata, '0);
    check("rst_b_rdata", b_rdata, '0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_hold_a_rvalid", s_line'(a_rvalid), '0);
    end
    idle_inputs();
    for (int w = 0; w < num_ways; w++)
      for (int s = 0; s < num_sets; s++)
        mdl[w][s] = '0;
    exp_a_q.delete();
    exp_b_q.delete();
    init_cnt  = 0;
    exp_ready = 1'b0;
    rst = 1'b0;
    check("post_rst_ready", s_line'(ready), '0);
  endtask

  initial begin
    logic [s_line-1:0] coll_exp;
    idle_inputs();
    #2;
    do_reset();

    // Init sweep: ready low for num_sets cycles, then high.
    repeat (num_sets) step();

    // Read way1/set7 after sweep -> zero.
    a_read = 1; a_way = 1; a_set = 7;
    step();
    step();

    // Full-line A write, then read back.
    a_wmask = '1; a_wdata = {s_mask{8'hA5}}; a_way = 0; a_set = 3;
    step();
    a_read = 1; a_way = 0; a_set = 3;
    step();
    step();

    // B partial write forwarded into A's same-cycle read.
    b_wmask = 32'h0000_000F; b_wdata = '0; b_wdata[31:0] = 32'h1122_3344;
    b_way = 0; b_set = 3;
    a_read = 1; a_way = 0; a_set = 3;
    step();
    a_read = 1; a_way = 0; a_set = 3;
    step();
    step();

    // Same-target collision: A wins overlapping bytes, union elsewhere.
    a_wmask = 32'h0000_00FF; a_wdata = {s_mask{8'h01}}; a_way = 1; a_set = 5;
    b_wmask = 32'h0000_FFFF; b_wdata = {s_mask{8'h02}}; b_way = 1; b_set = 5;
    step();
    coll_exp = '0;
    coll_exp[63:0]   = {8{8'h01}};
    coll_exp[127:64] = {8{8'h02}};
    check("collision_model", mdl[1][5], coll_exp);
    a_read = 1; a_way = 1; a_set = 5;
    b_read = 1; b_way = 1; b_set = 5;
    step();
    step();

    // Random mixed traffic on a few hot lines to provoke collisions.
    for (int n = 0; n < 40; n++) begin
      a_read = 1'($urandom); a_way = s_way'($urandom_range(0, 1));
      a_set = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'd5;
      a_wmask = ($urandom_range(0, 2) == 0) ? '0 : $urandom;
      a_wdata = {8{$urandom}};
      b_read = 1'($urandom); b_way = s_way'($urandom_range(0, 1));
      b_set = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'd5;
      b_wmask = ($urandom_range(0, 2) == 0) ? '0 : $urandom;
      b_wdata = {8{$urandom}};
      step();
    end
    step();

    // Requests during INIT are ignored; set 0 is swept before cycle 2.
    do_reset();
    step();
    a_wmask = '1; a_wdata = '1; a_way = 1; a_set = 0; a_read = 1;
    step();
    repeat (num_sets - 2) step();
    a_read = 1; a_way = 1; a_set = 0;
    step();
    step();

    // Mid-operation reset drops the pending read and re-zeroes lines.
    a_wmask = '1; a_wdata = {s_mask{8'h5A}}; a_way = 0; a_set = 1;
    step();
    a_read = 1; a_way = 0; a_set = 1;
    do_reset();
    repeat (num_sets) step();
    a_read = 1; a_way = 0; a_set = 1;
    b_read = 1; b_way = 1; b_set = 5;
    step();
    step();

    check("a_queue_empty", s_line'(exp_a_q.size()), '0);
    check("b_queue_empty", s_line'(exp_b_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
